// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request channel into the RV32I instruction encoder
//
// Purpose: groups the request handshake and instruction fields.
//   master: drives req_valid and the fields, samples req_ready (sequencer side)
//   slave : samples req_valid and the fields, drives req_ready (encoder side)
// Signals:
//   req_valid / req_ready  transfer when both are high on a rising clock edge
//   req_op      4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR,
//                  7 LUI, 8 AUIPC, 9 LI; anything else is illegal
//   req_funct3  3  funct3 field
//   req_alt     1  selects funct7 = 0100000 (SUB, SRA, SRAI)
//   req_rd/rs1/rs2 5 register indices
//   req_imm     32 signed immediate or byte offset
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;

    modport master (
        output req_valid, req_op, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm,
        output req_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes RV32I requests into words and writes them to instruction memory
//
// Purpose: turns one request per accepted handshake into a 32-bit RV32I word and
// writes it sequentially (step 4 bytes) into the instruction memory write port.
// Illegal ops or out-of-range immediates consume the request, write nothing and
// set the sticky err flag. Address wrap also sets err.
// Optional feature macro: ENCODER_LI_EXPAND_EN enables the LI pseudo-op (req_op=9),
// expanded into ADDI or LUI(+ADDI) using the extra LI_LO state.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        pulse: restart at BASE_ADDR, clear err and instr_count
//   req          instr_encoder_if.slave request channel
//   mem_we       one-cycle write strobe
//   mem_addr     byte address of the word on mem_wdata
//   mem_wdata    encoded instruction word
//   instr_count  words written since start/reset, saturates at 0xFFFF
//   err          sticky error flag
module instr_encoder #(
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    instr_encoder_if.slave        req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [15:0]           instr_count,
    output logic                  err
);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  funct7;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        is_shift;
    logic        enc_legal;
    logic [31:0] enc_word;
    logic        accept;

    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [15:0]           cur_cnt;
    logic                  emit;
    logic [31:0]           emit_word;
    logic                  carry;

`ifdef ENCODER_LI_EXPAND_EN
    typedef enum logic {RUN, LI_LO} state_t;
    state_t      state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic        enc_two;
    logic [31:0] enc_lo;
    logic [31:0] li_hi;

    // Rounding the upper part compensates for the sign-extended low 12 bits of the ADDI.
    assign li_hi         = imm + 32'h0000_0800;
    assign req.req_ready = (state_q == RUN);
`else
    assign req.req_ready = 1'b1;
`endif

    assign imm      = req.req_imm;
    assign rd       = req.req_rd;
    assign rs1      = req.req_rs1;
    assign rs2      = req.req_rs2;
    assign f3       = req.req_funct3;
    assign funct7   = req.req_alt ? 7'b0100000 : 7'b0000000;
    // A value fits N signed bits when every bit from N-1 upward equals the sign.
    assign fits12   = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits13   = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign fits21   = (imm[31:20] == '0) || (imm[31:20] == '1);
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign accept   = req.req_valid && req.req_ready;

    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
`ifdef ENCODER_LI_EXPAND_EN
        enc_two   = 1'b0;
        enc_lo    = '0;
`endif
        case (req.req_op)
            4'd0: enc_word = {funct7, rs2, rs1, f3, rd, OPC_R};
            4'd1: begin
                if (is_shift) begin
                    enc_legal = (imm[31:5] == '0);
                    enc_word  = {funct7, imm[4:0], rs1, f3, rd, OPC_I};
                end else begin
                    enc_legal = fits12;
                    enc_word  = {imm[11:0], rs1, f3, rd, OPC_I};
                end
            end
            4'd2: begin
                enc_legal = fits12;
                enc_word  = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            end
            4'd3: begin
                enc_legal = fits12;
                enc_word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            end
            4'd4: begin
                enc_legal = fits13 && !imm[0];
                enc_word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            end
            4'd5: begin
                enc_legal = fits21 && !imm[0];
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            end
            4'd6: begin
                enc_legal = fits12;
                enc_word  = {imm[11:0], rs1, f3, rd, OPC_JALR};
            end
            4'd7: begin
                enc_legal = (imm[11:0] == '0);
                enc_word  = {imm[31:12], rd, OPC_LUI};
            end
            4'd8: begin
                enc_legal = (imm[11:0] == '0);
                enc_word  = {imm[31:12], rd, OPC_AUIPC};
            end
`ifdef ENCODER_LI_EXPAND_EN
            4'd9: begin
                if (fits12) begin
                    enc_word = {imm[11:0], 5'd0, 3'b000, rd, OPC_I};
                end else begin
                    enc_word = {li_hi[31:12], rd, OPC_LUI};
                    enc_two  = (imm[11:0] != '0);
                    enc_lo   = {imm[11:0], rd, 3'b000, rd, OPC_I};
                end
            end
`endif
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        // start takes effect in the same cycle, so a simultaneous request lands at BASE.
        cur_addr   = start ? BASE : addr_q;
        cur_cnt    = start ? 16'd0 : cnt_q;
        addr_d     = cur_addr;
        cnt_d      = cur_cnt;
        err_d      = start ? 1'b0 : err_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        emit       = 1'b0;
        emit_word  = '0;
        carry      = 1'b0;
`ifdef ENCODER_LI_EXPAND_EN
        state_d    = start ? RUN : state_q;
        pend_d     = pend_q;
        // A start during LI_LO drops the pending ADDI.
        if (state_q == LI_LO && !start) begin
            emit      = 1'b1;
            emit_word = pend_q;
            state_d   = RUN;
        end
`endif
        if (accept) begin
            if (enc_legal) begin
                emit      = 1'b1;
                emit_word = enc_word;
`ifdef ENCODER_LI_EXPAND_EN
                if (enc_two) begin
                    state_d = LI_LO;
                    pend_d  = enc_lo;
                end
`endif
            end else begin
                err_d = 1'b1;
            end
        end
        if (emit) begin
            mem_we_d        = 1'b1;
            mem_addr_d      = cur_addr;
            wdata_d         = emit_word;
            {carry, addr_d} = {1'b0, cur_addr} + (ADDR_WIDTH+1)'(4);
            if (carry) begin
                err_d = 1'b1;
            end
            if (cur_cnt != 16'hFFFF) begin
                cnt_d = cur_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= BASE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE;
            wdata_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
`ifdef ENCODER_LI_EXPAND_EN
            state_q    <= RUN;
            pend_q     <= '0;
`endif
        end else begin
            addr_q     <= addr_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`ifdef ENCODER_LI_EXPAND_EN
            state_q    <= state_d;
            pend_q     <= pend_d;
`endif
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = wdata_q;
    assign instr_count = cnt_q;
    assign err         = err_q;
endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Encodes RV32I instruction requests (operation class, registers, immediate, funct fields) into 32-bit instruction words.
- Writes each word sequentially into instruction memory through a write port.
- It is the encode-side counterpart of the core's control/decode unit and feeds the pipelined core's instruction memory from a test or boot sequencer.
- Optionally expands the LI pseudo-instruction into LUI+ADDI.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte-address width of the instruction memory write port
- BASE_ADDR, 0, first write address after reset or start

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: restart at BASE_ADDR, clear err and instr_count
- req_valid  in  1  request valid
- req_ready  out  1  request ready; transfer when req_valid && req_ready
- req_op  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 LI; others illegal
- req_funct3  in  3  funct3 field (ignored for JAL/LUI/AUIPC/LI)
- req_alt  in  1  selects funct7=0100000 (SUB, SRA, SRAI)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  32  signed immediate or byte offset
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_WIDTH  write byte address
- mem_wdata  out  32  encoded instruction word
- instr_count  out  16  words written since start, saturating at 0xFFFF
- err  out  1  sticky error flag

## Operation
Opcodes are fixed per class:
- R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011
- JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111

Immediate rules:
- I/LOAD/JALR: req_imm must fit signed 12 bits.
- Shift ops (I-ALU, funct3 001/101): imm[4:0] only; funct7 = req_alt ? 0100000 : 0000000; req_imm[31:5] must be 0.
- STORE: signed 12 bits, S split.
- BRANCH: signed 13 bits, bit0 = 0, B split.
- JAL: signed 21 bits, bit0 = 0.
- LUI/AUIPC: word uses req_imm[31:12]; req_imm[11:0] must be 0.
- R-type: funct7 = req_alt ? 0100000 : 0000000. For non-shift I-ALU, req_alt is ignored.

Error handling:
- An illegal req_op or out-of-range immediate consumes the request, writes nothing, and sets err.
- err stays set until start or reset.

FSM states: RUN, LI_LO.
- RUN: req_ready=1. Each accepted legal request produces one word; LI may move the FSM to LI_LO.
- LI_LO: req_ready=0. Emits ADDI rd,rd,imm[11:0], then returns to RUN.

The write address register starts at BASE_ADDR and increments by 4 after each word. It wraps modulo 2^ADDR_WIDTH; each wrap sets err.

## Timing
- Reset: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, instr_count=0, err=0, req_ready=1, FSM=RUN.
- Latency: a request accepted at edge N appears on mem_we/mem_addr/mem_wdata for exactly one cycle after edge N (registered outputs).
- Back-to-back requests give one word per cycle.
- LI expansion:
  - Fits signed 12 bits: a single ADDI rd,x0,imm.
  - Otherwise: LUI rd,(imm+0x800)>>12, then ADDI in the next cycle.
  - ADDI is omitted when imm[11:0]=0.
  - req_ready is low for the LI_LO cycle only.
- start with a simultaneous accept: the address loads BASE_ADDR and the request is written at BASE_ADDR; instr_count becomes 1 for that word.
- start during LI_LO: the pending ADDI is discarded and the FSM returns to RUN.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Any pending LI half is lost.
- instr_count increments with every mem_we pulse and saturates.

## Configuration
- ENCODER_LI_EXPAND_EN defined: req_op=9 is supported and the LI_LO state exists.
- Undefined: req_op=9 is illegal (sets err, no write), the FSM is only RUN, and req_ready is constantly 1 outside reset.

## Test plan
- ADD x3,x1,x2 (op0, f3 0, alt0) after reset -> next cycle mem_we=1, mem_addr=0x000, mem_wdata=0x002081B3; instr_count=1.
- SUB x5,x6,x7 then ADDI x1,x0,-1 back-to-back -> 0x407302B3 at 0x000, then 0xFFF00093 at 0x004 on consecutive cycles.
- BEQ x1,x2,+8 -> 0x00208463 written. Then BEQ with imm=7 -> no mem_we, err=1. Then start -> err=0, next word at 0x000.
- LI x10,0x12345FFF (macro defined) -> 0x12346537 at 0x000, then 0xFFF50513 at 0x004; req_ready low for one cycle. Without the macro -> no write, err=1.
- ADDR_WIDTH=4, five ADDI requests -> addresses 0x0, 0x4, 0x8, 0xC, 0x0; err=1 after the wrap.
- rst_n low during LI_LO -> outputs at reset values immediately; no ADDI word after release.
